// File: rtl/demux2reg_pair_pkg.sv
// Shared definitions for the demux2reg_pair slice.
//   state_e          : FSM state encoding (EMPTY/HALF/FULL; 2'b11 is unused
//                      and recovers to EMPTY)
//   DEFAULT_BITS     : default data word width
//   DEFAULT_CNT_BITS : default delivered-pair counter width
package demux2reg_pair_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,  // next word goes to A
    HALF  = 2'b01,  // A loaded, next word goes to B
    FULL  = 2'b10   // pair held
  } state_e;

  localparam int unsigned DEFAULT_BITS     = 3;
  localparam int unsigned DEFAULT_CNT_BITS = 4;

endpackage

// File: rtl/demux2reg_pair_bit_reg.sv
// demux_bit_reg: one bit of a holding register.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset, clears q_o
//   load_i : 1 selects d_i, 0 holds the current value
//   d_i    : data to load
//   q_o    : registered bit
module demux_bit_reg (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) q_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/demux2reg_pair.sv
// demux2reg_pair: splits a valid/ready word stream alternately into holding
// registers A and B and presents each completed pair on a valid/ready output.
//   clock, reset          : system clock; synchronous active-high reset
//   in_valid/in_ready     : input handshake, in_data is the word
//   out_valid/out_ready   : output handshake, A/B is the pair
//   pair_count            : pairs consumed, modulo 2^cnt_bits
module demux2reg_pair
  import demux2reg_pair_pkg::*;
#(
  parameter int unsigned bits     = DEFAULT_BITS,
  parameter int unsigned cnt_bits = DEFAULT_CNT_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [bits-1:0]     in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [bits-1:0]     A,
  output logic [bits-1:0]     B,
  output logic [cnt_bits-1:0] pair_count
);

  state_e              state_q;
  state_e              state_d;
  logic [cnt_bits-1:0] pair_count_q;
  logic [cnt_bits-1:0] pair_count_d;
  logic                accept;
  logic                consume;
  logic                load_a;
  logic                load_b;

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      EMPTY:   in_ready = 1'b1;
      HALF:    in_ready = 1'b1;
      FULL: begin
        // Pass-through accept: a new word may enter only as the pair leaves.
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // An accept in FULL implies a consume, so it always starts a new pair in A.
  assign load_a = accept & ((state_q == EMPTY) | (state_q == FULL));
  assign load_b = accept & (state_q == HALF);

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = HALF;
      HALF:  if (accept) state_d = FULL;
      FULL: begin
        if (consume) state_d = accept ? HALF : EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    pair_count_d = pair_count_q;
    if (consume) pair_count_d = pair_count_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= EMPTY;
      pair_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pair_count_q <= pair_count_d;
    end
  end

  for (genvar i = 0; i < bits; i++) begin : g_bit
    demux_bit_reg u_a (
      .clk_i  (clock),
      .rst_i  (reset),
      .load_i (load_a),
      .d_i    (in_data[i]),
      .q_o    (A[i])
    );
    demux_bit_reg u_b (
      .clk_i  (clock),
      .rst_i  (reset),
      .load_i (load_b),
      .d_i    (in_data[i]),
      .q_o    (B[i])
    );
  end

  assign pair_count = pair_count_q;

endmodule
